// File: rtl/apb_decoder_tmo.sv
`default_nettype none
// ============================================================================
// Module   : apb_decoder_tmo
// Purpose  : APB address decoder and response multiplexer. Decodes a PADDR
//            bit-field into one-hot slave selects and muxes the slave response.
//            Also returns an error for unmapped indices, forces an error when
//            a slave stalls too long, and keeps a sticky timeout flag and a
//            saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module apb_decoder_tmo #(
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_MSB        = 23,
  parameter int SEL_LSB        = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [31:0]           PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRData_in [NUM_SLAVES],
  input  logic [NUM_SLAVES-1:0] PREADY_in,
  input  logic [NUM_SLAVES-1:0] PSLVERR_in,
  output logic [NUM_SLAVES-1:0] PSEL_slave,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  tmo_flag,
  input  logic                  tmo_clr,
  output logic [ERR_CNT_W-1:0]  err_count
);

  // Index field width, latched slave-index width and wait-counter width.
  // The index field is assumed to be at most 32 bits wide.
  localparam int IW = SEL_MSB - SEL_LSB + 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TMO    = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [31:0]     idx_ext;
  logic [SW-1:0]   slv;
  logic            mapped;
  logic [SW-1:0]   idx_l;
  logic            mapped_l;
  logic [CW-1:0]   wait_cnt;
  logic            setup_take;
  logic            wait_inc;
  logic            sel_hit;
  logic [SW-1:0]   sel_idx;
  logic            ready;
  logic            slverr;
  logic [DATA_WIDTH-1:0] rdata;
  logic            err_evt;
  logic            unused_bits;

  // Live decode of the address field. A mapped index always fits in SW bits.
  assign idx         = PADDR[SEL_MSB:SEL_LSB];
  assign idx_ext     = 32'(idx);
  assign mapped      = (idx_ext < 32'(NUM_SLAVES));
  assign slv         = idx_ext[SW-1:0];
  assign unused_bits = ^{PADDR, idx_ext};

  // Next-state and response selection; every output defaults to idle values.
  always_comb begin
    state_nxt  = state;
    setup_take = 1'b0;
    wait_inc   = 1'b0;
    sel_hit    = 1'b0;
    sel_idx    = '0;
    ready      = 1'b0;
    slverr     = 1'b0;
    rdata      = '0;
    case (state)
      IDLE: begin
        sel_hit = PSEL && mapped;
        sel_idx = slv;
        if (PSEL && !PENABLE) begin
          setup_take = 1'b1;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Bridge abandoned the transfer: no response, nothing counted.
          state_nxt = IDLE;
        end else if (!mapped_l) begin
          ready     = 1'b1;
          slverr    = 1'b1;
          state_nxt = IDLE;
        end else begin
          sel_hit = 1'b1;
          sel_idx = idx_l;
          ready   = PREADY_in[idx_l];
          slverr  = PSLVERR_in[idx_l] & ready;
          rdata   = ready ? PRData_in[idx_l] : '0;
          if (ready) begin
            state_nxt = IDLE;
          end else begin
            wait_inc = 1'b1;
            if ((TIMEOUT_CYCLES != 0) && (wait_cnt == TMO_LAST)) begin
              state_nxt = TMO;
            end
          end
        end
      end
      TMO: begin
        // Forced error completion; the stalled slave is ignored from here on.
        ready     = 1'b1;
        slverr    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign err_evt = ready & slverr;

  // One-hot select, held at zero while reset is asserted.
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_sel
    assign PSEL_slave[g] = HRESETn & sel_hit & (sel_idx == SW'(g));
  end

  assign PREADY  = HRESETn & ready;
  assign PSLVERR = HRESETn & slverr;
  assign PRDATA  = HRESETn ? rdata : '0;

  // State register, latched slave index and wait-state counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      idx_l    <= '0;
      mapped_l <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (setup_take) begin
        idx_l    <= slv;
        mapped_l <= mapped;
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Sticky timeout flag and saturating error counter; clear has priority.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tmo_flag  <= 1'b0;
      err_count <= '0;
    end else if (tmo_clr) begin
      tmo_flag  <= 1'b0;
      err_count <= '0;
    end else begin
      if (state == TMO) begin
        tmo_flag <= 1'b1;
      end
      if (err_evt && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_decoder_tmo.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_decoder_tmo
// Purpose  : Scoreboard bench for apb_decoder_tmo (4 slaves, 8-cycle timeout,
//            2-bit error counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_decoder_tmo;

  localparam int NS      = 4;
  localparam int DW      = 32;
  localparam int TMO_CYC = 8;
  localparam int EW      = 2;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic [31:0]   PADDR = '0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic [DW-1:0] prdata_in [NS];
  logic [NS-1:0] pready_in = '0;
  logic [NS-1:0] pslverr_in = '0;
  logic [NS-1:0] PSEL_slave;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic          tmo_flag;
  logic          tmo_clr = 1'b0;
  logic [EW-1:0] err_count;

  apb_decoder_tmo #(
    .NUM_SLAVES(NS), .SEL_MSB(23), .SEL_LSB(16), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO_CYC), .ERR_CNT_W(EW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRData_in(prdata_in), .PREADY_in(pready_in),
    .PSLVERR_in(pslverr_in), .PSEL_slave(PSEL_slave), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .tmo_flag(tmo_flag),
    .tmo_clr(tmo_clr), .err_count(err_count)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          slverr;
    int            cycles;
    logic [NS-1:0] psel;
    logic          tmo;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            slv_wait [NS];
  logic [EW-1:0] exp_err = '0;
  logic          exp_tmo = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete APB transfer. Expected response is pushed at setup and
  // popped when PREADY is seen. glitch_addr replaces PADDR in ACCESS cycle 2.
  task automatic apb_xfer(input logic [31:0] addr, input logic [31:0] glitch_addr,
                          input bit clr_at_end);
    exp_t e;
    exp_t g;
    int   idx;
    bit   done;
    idx = int'(addr[23:16]);
    if (idx >= NS) begin
      e.rdata = '0; e.slverr = 1'b1; e.cycles = 1; e.psel = '0; e.tmo = 1'b0;
    end else if (slv_wait[idx] >= TMO_CYC) begin
      e.rdata = '0; e.slverr = 1'b1; e.cycles = TMO_CYC + 1;
      e.psel = NS'(1) << idx; e.tmo = 1'b1;
    end else begin
      e.rdata = prdata_in[idx]; e.slverr = pslverr_in[idx];
      e.cycles = slv_wait[idx] + 1; e.psel = NS'(1) << idx; e.tmo = 1'b0;
    end
    sb.push_back(e);

    @(posedge HCLK); #1;
    PADDR = addr; PSEL = 1'b1; PENABLE = 1'b0;
    #1;
    check("setup_psel", PSEL_slave, e.psel);
    check("setup_pready", PREADY, 1'b0);
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    done = 1'b0;
    for (int k = 1; k <= TMO_CYC + 4 && !done; k++) begin
      for (int s = 0; s < NS; s++) pready_in[s] = (k > slv_wait[s]);
      if (k == 2) PADDR = glitch_addr;
      if (clr_at_end && k == e.cycles) tmo_clr = 1'b1;
      #1;
      if (PREADY) begin
        g = sb.pop_front();
        check("cycles", k, g.cycles);
        check("rdata", PRDATA, g.rdata);
        check("slverr", PSLVERR, g.slverr);
        check("psel_done", PSEL_slave, g.tmo ? '0 : g.psel);
        if (clr_at_end) begin
          exp_err = '0; exp_tmo = 1'b0;
        end else begin
          if (g.slverr && exp_err != '1) exp_err = exp_err + 1'b1;
          if (g.tmo) exp_tmo = 1'b1;
        end
        done = 1'b1;
      end else begin
        check("psel_wait", PSEL_slave, e.psel);
        check("rdata_wait", PRDATA, '0);
        @(posedge HCLK); #1;
      end
    end
    if (!done) begin
      check("xfer_bound", 1'b0, 1'b1);
      void'(sb.pop_front());
    end
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; tmo_clr = 1'b0; pready_in = '0;
    #1;
    check("err_count", err_count, exp_err);
    check("tmo_flag", tmo_flag, exp_tmo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < NS; s++) begin
      prdata_in[s] = 32'h1000_0000 + 32'(s * 32'h111);
      slv_wait[s]  = 0;
    end

    // Reset state: outputs held at zero even with a mapped select present.
    PADDR = 32'h0002_0000; PSEL = 1'b1;
    #12;
    check("rst_psel", PSEL_slave, '0);
    check("rst_pready", PREADY, 1'b0);
    check("rst_err_count", err_count, '0);
    check("rst_tmo_flag", tmo_flag, 1'b0);
    PSEL = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1;

    // Mapped read, zero wait.
    prdata_in[2] = 32'hDEAD_BEEF;
    apb_xfer(32'h0002_0010, 32'h0002_0010, 1'b0);

    // Wait states with PADDR glitch mid-ACCESS.
    slv_wait[1] = 3;
    apb_xfer(32'h0001_0000, 32'h0003_0000, 1'b0);
    slv_wait[1] = 0;

    // Unmapped index.
    apb_xfer(32'h0005_0000, 32'h0005_0000, 1'b0);

    // Slave-reported error after one wait state.
    pslverr_in[3] = 1'b1; slv_wait[3] = 1;
    apb_xfer(32'h0003_0004, 32'h0003_0004, 1'b0);
    pslverr_in[3] = 1'b0; slv_wait[3] = 0;

    // Timeout: slave 0 answers only in the TMO cycle, which must be ignored.
    slv_wait[0] = TMO_CYC;
    apb_xfer(32'h0000_0000, 32'h0000_0000, 1'b0);
    slv_wait[0] = 0;

    // Saturation, then clear coinciding with a further error.
    for (int i = 0; i < 5; i++) apb_xfer(32'h0005_0000, 32'h0005_0000, 1'b0);
    check("sat_count", err_count, 2'd3);
    apb_xfer(32'h00FF_0000, 32'h00FF_0000, 1'b1);

    // Normal read after clear, then one error so the counter is non-zero.
    apb_xfer(32'h0003_0000, 32'h0003_0000, 1'b0);
    apb_xfer(32'h0009_0000, 32'h0009_0000, 1'b0);

    // Asynchronous reset during a wait state.
    @(posedge HCLK); #1;
    PADDR = 32'h0001_0000; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1; pready_in = '0;
    #1;
    check("pre_rst_psel", PSEL_slave, 4'b0010);
    #1;
    HRESETn = 1'b0; pready_in[1] = 1'b1;
    #1;
    check("arst_psel", PSEL_slave, '0);
    check("arst_pready", PREADY, 1'b0);
    check("arst_pslverr", PSLVERR, 1'b0);
    check("arst_prdata", PRDATA, '0);
    check("arst_err_count", err_count, '0);
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; pready_in = '0;
    HRESETn = 1'b1;
    exp_err = '0; exp_tmo = 1'b0;
    sb.delete();

    // Normal decode after reset.
    prdata_in[1] = 32'hCAFE_F00D;
    apb_xfer(32'h0001_0008, 32'h0001_0008, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
